// File: rtl/data_mem_responder.sv
// Wait-state data-memory responder for the Harvard MIPS core data port.
// Optional DATA_MEM_ALIGN_CHECK_EN: reject accesses whose address is not word aligned.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        stall,
    output logic        err
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        load;
    logic [31:0] lat_addr, lat_wdata;
    logic [3:0]  lat_be;
    logic        lat_rd, lat_wr;

    logic [31:0] mem [DEPTH_WORDS];

    logic          req, resp, ok, align_ok;
    logic          cur_rd, cur_wr;
    logic [31:0]   cur_addr, cur_wdata, off;
    logic [3:0]    cur_be;
    logic [AW-1:0] idx;

    assign req = data_read | data_write;

    // The IDLE cycle that accepts a request is itself the first stall cycle,
    // so WAIT leaves for RESP once the counter would reach zero.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (req && WAIT_CYCLES != 0) begin
                    load    = 1'b1;
                    cnt_n   = 4'(WAIT_CYCLES - 1);
                    state_n = (WAIT_CYCLES == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt <= 4'd1) begin
                    state_n = RESP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load) begin
                lat_addr  <= data_address;
                lat_wdata <= data_writedata;
                lat_be    <= data_byteenable;
                lat_rd    <= data_read;
                lat_wr    <= data_write;
            end
        end
    end

    // Zero-wait accesses respond in the IDLE cycle straight from the live inputs.
    always_comb begin
        if (state == IDLE) begin
            cur_addr  = data_address;
            cur_wdata = data_writedata;
            cur_be    = data_byteenable;
            cur_rd    = data_read;
            cur_wr    = data_write;
        end else begin
            cur_addr  = lat_addr;
            cur_wdata = lat_wdata;
            cur_be    = lat_be;
            cur_rd    = lat_rd;
            cur_wr    = lat_wr;
        end
        resp = (state == RESP) || (state == IDLE && req && WAIT_CYCLES == 0);
        off  = cur_addr - BASE_ADDR;
`ifdef DATA_MEM_ALIGN_CHECK_EN
        align_ok = (cur_addr[1:0] == 2'b00);
`else
        align_ok = 1'b1;
`endif
        ok  = !(cur_rd && cur_wr) && (cur_addr >= BASE_ADDR) && (off < SPAN) && align_ok;
        idx = off[AW+1:2];
    end

    assign stall = !reset && req && ((state == IDLE && WAIT_CYCLES != 0) || state == WAIT);
    assign err   = !reset && resp && !ok;
    assign data_readdata = (!reset && resp && ok && cur_rd) ? mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (!reset && resp && ok && cur_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (cur_be[b]) mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end

endmodule
